// File: rtl/divider_unit.sv
// Sequential restoring divider: unsigned WIDTH-bit dividend / divisor -> quotient + remainder,
// one quotient bit per clock, started by a button-style Run level with a preloaded divisor.
module divider_unit #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Ld_Dvsr,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Dvsr,
    output logic             Busy,
    output logic             Done,
    output logic             Div_Zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] q_n, r_n, dvsr_n;
    logic [CW-1:0]    count, count_n;
    logic             dz_n;
    logic [WIDTH:0]   diff;

    // Trial subtract of the shifted partial remainder; diff[WIDTH] set means borrow.
    assign diff = {R, Q[WIDTH-1]} - {1'b0, Dvsr};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            Q        <= '0;
            R        <= '0;
            Dvsr     <= '0;
            count    <= '0;
            Div_Zero <= 1'b0;
        end else begin
            state    <= state_n;
            Q        <= q_n;
            R        <= r_n;
            Dvsr     <= dvsr_n;
            count    <= count_n;
            Div_Zero <= dz_n;
        end
    end

    always_comb begin
        state_n = state;
        q_n     = Q;
        r_n     = R;
        dvsr_n  = Dvsr;
        count_n = count;
        dz_n    = Div_Zero;
        unique case (state)
            IDLE: begin
                // A divisor load takes priority over a start in the same cycle.
                if (Ld_Dvsr) begin
                    dvsr_n = D;
                end else if (Run) begin
                    if (Dvsr != '0) begin
                        r_n     = '0;
                        q_n     = D;
                        count_n = '0;
                        dz_n    = 1'b0;
                        state_n = CALC;
                    end else begin
                        q_n     = '1;
                        r_n     = D;
                        dz_n    = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            CALC: begin
                if (!diff[WIDTH]) begin
                    r_n = diff[WIDTH-1:0];
                    q_n = {Q[WIDTH-2:0], 1'b1};
                end else begin
                    r_n = {R[WIDTH-2:0], Q[WIDTH-1]};
                    q_n = {Q[WIDTH-2:0], 1'b0};
                end
                count_n = count + 1'b1;
                if (count == CW'(WIDTH - 1)) state_n = DONE;
            end
            DONE: begin
                // Stay here while Run is held so one press yields exactly one division.
                if (!Run) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign Busy = (state == CALC);
    assign Done = (state == DONE);

endmodule

// File: tb/tb_divider_unit.sv
// Directed self-checking bench for divider_unit (WIDTH=8): reset, normal divisions,
// divide-by-zero, Run held in DONE, divisor load during CALC, and mid-operation reset.
module tb_divider_unit;
    logic       Clk = 1'b0;
    logic       Reset, Run, Ld_Dvsr;
    logic [7:0] D, Q, R, Dvsr;
    logic       Busy, Done, Div_Zero;

    int checks = 0;
    int errors = 0;
    int lat, bcnt, dcnt;

    divider_unit #(.WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Ld_Dvsr(Ld_Dvsr), .D(D),
        .Q(Q), .R(R), .Dvsr(Dvsr), .Busy(Busy), .Done(Done), .Div_Zero(Div_Zero)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for Done, counting elapsed cycles and Busy cycles.
    task automatic wait_done(output int cycles, output int busy_cycles);
        cycles = 0;
        busy_cycles = 0;
        while (!Done && cycles < 30) begin
            if (Busy) busy_cycles++;
            tick();
            cycles++;
        end
    endtask

    task automatic load_dvsr(input logic [7:0] v);
        Ld_Dvsr = 1'b1; D = v;
        tick();
        Ld_Dvsr = 1'b0;
    endtask

    // Load divisor, press Run for one cycle, then measure the operation.
    task automatic divide(input string tag, input logic [7:0] dv, input logic [7:0] dd,
                          input int exp_lat, input logic [7:0] eq, input logic [7:0] er,
                          input logic edz);
        load_dvsr(dv);
        Run = 1'b1; D = dd;
        tick();
        Run = 1'b0; D = 8'hA5;
        wait_done(lat, bcnt);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy"}, bcnt, exp_lat);
        check({tag, "_q"}, Q, eq);
        check({tag, "_r"}, R, er);
        check({tag, "_dz"}, Div_Zero, edz);
    endtask

    initial begin
        Reset = 1'b1; Run = 1'b0; Ld_Dvsr = 1'b0; D = 8'h00;
        tick(); tick();
        Reset = 1'b0;
        check("rst_q", Q, 0);
        check("rst_r", R, 0);
        check("rst_dvsr", Dvsr, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_dz", Div_Zero, 0);

        // Load wins over Run in the same IDLE cycle.
        Ld_Dvsr = 1'b1; Run = 1'b1; D = 8'h07;
        tick();
        Ld_Dvsr = 1'b0; Run = 1'b0;
        check("ld_wins_dvsr", Dvsr, 8'h07);
        check("ld_wins_busy", Busy, 0);
        check("ld_wins_done", Done, 0);

        divide("d100_7", 8'h07, 8'h64, 8, 8'h0E, 8'h02, 1'b0);
        tick();
        check("to_idle_done", Done, 0);
        check("idle_hold_q", Q, 8'h0E);
        check("idle_hold_r", R, 8'h02);

        divide("d255_1", 8'h01, 8'hFF, 8, 8'hFF, 8'h00, 1'b0);
        tick();
        divide("d5_9", 8'h09, 8'h05, 8, 8'h00, 8'h05, 1'b0);
        tick();
        divide("dz", 8'h00, 8'h4D, 0, 8'hFF, 8'h4D, 1'b1);
        tick();
        check("dz_idle_done", Done, 0);

        // Run held after Done: single division, Done stays high.
        load_dvsr(8'h07);
        Run = 1'b1; D = 8'h64;
        tick();
        wait_done(lat, bcnt);
        check("hold_lat", lat, 8);
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (Done && !Busy) dcnt++;
        end
        check("hold_done_cycles", dcnt, 20);
        check("hold_q", Q, 8'h0E);
        check("hold_r", R, 8'h02);
        Run = 1'b0;
        tick();
        check("release_done", Done, 0);
        check("release_busy", Busy, 0);
        Run = 1'b1; D = 8'h10;
        tick();
        Run = 1'b0;
        check("restart_busy", Busy, 1);
        wait_done(lat, bcnt);
        check("restart_lat", lat, 8);
        check("restart_q", Q, 8'h02);
        check("restart_r", R, 8'h02);
        tick();

        // Divisor load attempted during CALC is ignored.
        Run = 1'b1; D = 8'h64;
        tick();
        Run = 1'b0;
        tick(); tick();
        Ld_Dvsr = 1'b1; D = 8'h03;
        tick();
        Ld_Dvsr = 1'b0;
        check("calc_ld_dvsr", Dvsr, 8'h07);
        wait_done(lat, bcnt);
        check("calc_ld_lat", lat, 5);
        check("calc_ld_q", Q, 8'h0E);
        check("calc_ld_r", R, 8'h02);
        tick();

        // Reset mid-operation aborts with no Done afterwards.
        Run = 1'b1; D = 8'h64;
        tick();
        Run = 1'b0;
        tick(); tick(); tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("abort_q", Q, 0);
        check("abort_r", R, 0);
        check("abort_dvsr", Dvsr, 0);
        check("abort_busy", Busy, 0);
        check("abort_done", Done, 0);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (Done || Busy) dcnt++;
        end
        check("abort_no_done", dcnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
